// File: rtl/cfglut_pkg.sv
// cfglut_pkg: shared FSM state type and sizes for the CFGLUT5 reconfiguration loader
package cfglut_pkg;
    localparam int LUT_BITS = 32;
    localparam int CNT_W    = 5;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
endpackage

// File: rtl/cfglut_shifter.sv
// cfglut_shifter: serialises new INIT contents MSB first while capturing the old contents from CDO
module cfglut_shifter
    import cfglut_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clr,
    input  logic                shift,
    input  logic [LUT_BITS-1:0] init,
    input  logic                cdo,
    output logic                cdi,
    output logic                last,
    output logic [LUT_BITS-1:0] old
);
    logic [LUT_BITS-1:0] sr_q, sr_d, cap_q, cap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        sr_d  = load ? init : shift ? {sr_q[LUT_BITS-2:0], 1'b0} : sr_q;
        cap_d = clr ? '0 : shift ? {cap_q[LUT_BITS-2:0], cdo} : cap_q;
        cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cap_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
        end
    end

    assign cdi  = sr_q[LUT_BITS-1];
    assign last = cnt_q == CNT_W'(LUT_BITS - 1);
    assign old  = cap_q;
endmodule

// File: rtl/cfglut_loader.sv
// cfglut_loader: request/response front end that reloads one of NUM_LUT CFGLUT5 primitives
// and returns the contents it replaced.
module cfglut_loader
    import cfglut_pkg::*;
#(
    parameter int NUM_LUT = 4,
    parameter int IDX_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_idx,
    input  logic [LUT_BITS-1:0] req_init,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LUT_BITS-1:0] rsp_old,
    output logic                rsp_err,
    output logic [NUM_LUT-1:0]  lut_ce,
    output logic                lut_cdi,
    input  logic [NUM_LUT-1:0]  lut_cdo,
    output logic [NUM_LUT-1:0]  lut_busy
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d, rdy_q;
    logic             accept, bad_idx, shifting, last, cdi_raw;

    // rdy_q keeps req_ready low through reset and for no longer than the first edge after it
    assign req_ready = rdy_q && state_q == IDLE;
    assign accept    = req_valid && req_ready;
    assign bad_idx   = 32'(req_idx) >= NUM_LUT;
    assign shifting  = state_q == SHIFT;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (accept) begin
            state_d = bad_idx ? RESP : SHIFT;
            idx_d   = bad_idx ? idx_q : req_idx;
            err_d   = bad_idx;
        end else if (shifting && last) begin
            state_d = RESP;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    cfglut_shifter u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && !bad_idx),
        .clr   (accept),
        .shift (shifting),
        .init  (req_init),
        .cdo   (lut_cdo[idx_q]),
        .cdi   (cdi_raw),
        .last  (last),
        .old   (rsp_old)
    );

    assign lut_ce    = shifting ? NUM_LUT'(1) << idx_q : '0;
    assign lut_busy  = lut_ce;
    assign lut_cdi   = shifting && cdi_raw;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_cfglut_loader.sv
// tb_cfglut_loader: drives the loader against behavioural CFGLUT5 shift registers and
// checks responses through an expected-response queue.
module tb_cfglut_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, lut_cdi;
    logic [1:0]  req_idx = '0;
    logic [31:0] req_init = '0, rsp_old;
    logic [3:0]  lut_ce, lut_cdo, lut_busy;
    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err, b_lut_cdi;
    logic [1:0]  b_req_idx = '0;
    logic [31:0] b_req_init = '0, b_rsp_old;
    logic [2:0]  b_lut_ce, b_lut_busy;
    logic [2:0]  b_lut_cdo = '0;
    logic [31:0] mem [4];
    logic [32:0] sb [$];
    int          cyc = 0;
    int          vecs = 0, errs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CFGLUT5 behaviour: shift CDI in at the LSB while CE is high, CDO is bit 31
    always @(posedge clk)
        for (int i = 0; i < 4; i++) if (lut_ce[i]) mem[i] <= {mem[i][30:0], lut_cdi};
    always_comb for (int i = 0; i < 4; i++) lut_cdo[i] = mem[i][31];

    cfglut_loader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_init(req_init), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_old(rsp_old), .rsp_err(rsp_err), .lut_ce(lut_ce), .lut_cdi(lut_cdi),
        .lut_cdo(lut_cdo), .lut_busy(lut_busy)
    );

    cfglut_loader #(.NUM_LUT(3), .IDX_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_idx(b_req_idx), .req_init(b_req_init), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_old(b_rsp_old), .rsp_err(b_rsp_err), .lut_ce(b_lut_ce), .lut_cdi(b_lut_cdi),
        .lut_cdo(b_lut_cdo), .lut_busy(b_lut_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one load, returns accept cycle, latency to rsp_valid and bad shift-cycle count
    task automatic do_load(input logic [1:0] idx, input logic [31:0] init,
                           output int acc, output int lat, output int bad);
        int n = 0;
        while (!req_ready && n < 200) begin tick(); n++; end
        req_valid = 1'b1; req_idx = idx; req_init = init;
        sb.push_back({1'b0, mem[idx]});
        tick();
        acc = cyc; req_valid = 1'b0; req_init = '0;
        bad = (n >= 200) ? 1 : 0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            if (lat > 32 || lut_ce !== (4'b0001 << idx) || lut_busy !== lut_ce ||
                lut_cdi !== init[32-lat]) bad++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vecs++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || lut_ce !== 4'b0 || lut_busy !== 4'b0 ||
            lut_cdi !== 1'b0 || rsp_old !== 32'h0 || rsp_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: ready=%b valid=%b ce=%b busy=%b cdi=%b old=%h err=%b, want all 0",
                     req_ready, rsp_valid, lut_ce, lut_busy, lut_cdi, rsp_old, rsp_err);
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load();
        int acc, lat, bad;
        logic [32:0] exp;
        rsp_ready = 1'b0;
        do_load(2'd1, 32'hDEADBEEF, acc, lat, bad);
        vecs++;
        if (bad !== 0) begin errs++; $display("FAIL load_shift: %0d bad ce/cdi cycles, want 0", bad); end
        vecs++;
        if (lat !== 33) begin errs++; $display("FAIL load_latency: got %0d want 33", lat); end
        exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
        vecs++;
        if ({rsp_err, rsp_old} !== exp) begin
            errs++; $display("FAIL load_rsp: got err=%b old=%h want err=%b old=%h", rsp_err, rsp_old, exp[32], exp[31:0]);
        end
        vecs++;
        if (mem[1] !== 32'hDEADBEEF) begin errs++; $display("FAIL load_model: got %h want deadbeef", mem[1]); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat, bad;
        logic [32:0] exp;
        rsp_ready = 1'b1;
        do_load(2'd0, 32'hAAAA5555, acc1, lat, bad);
        exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
        vecs++;
        if ({rsp_err, rsp_old} !== exp || bad !== 0) begin
            errs++; $display("FAIL b2b_first: got old=%h bad=%0d want old=%h bad=0", rsp_old, bad, exp[31:0]);
        end
        do_load(2'd0, 32'h0F0F0F0F, acc2, lat, bad);
        exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
        vecs++;
        if ({rsp_err, rsp_old} !== exp || exp !== {1'b0, 32'hAAAA5555}) begin
            errs++; $display("FAIL b2b_second: got old=%h want aaaa5555", rsp_old);
        end
        vecs++;
        if (acc2 - acc1 !== 34) begin errs++; $display("FAIL b2b_spacing: got %0d want 34", acc2 - acc1); end
        tick();
    endtask

    task automatic test_hold();
        int acc, lat, bad, unstable = 0;
        logic [31:0] old0;
        logic [32:0] exp;
        rsp_ready = 1'b0;
        do_load(2'd2, 32'h5A5AC3C3, acc, lat, bad);
        exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
        vecs++;
        if ({rsp_err, rsp_old} !== exp) begin
            errs++; $display("FAIL hold_rsp: got old=%h want %h", rsp_old, exp[31:0]);
        end
        old0 = rsp_old;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_old !== old0 || req_ready !== 1'b0 || lut_ce !== 4'b0) unstable++;
            if (i < 9) tick();
        end
        vecs++;
        if (unstable !== 0) begin errs++; $display("FAIL hold_stable: %0d unstable cycles, want 0", unstable); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vecs++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL hold_release: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_err_idx();
        int n = 0;
        logic [32:0] exp;
        while (!b_req_ready && n < 50) begin tick(); n++; end
        b_req_valid = 1'b1; b_req_idx = 2'd3; b_req_init = 32'hFFFFFFFF;
        sb.push_back({1'b1, 32'h0});
        tick();
        b_req_valid = 1'b0;
        exp = sb.size() > 0 ? sb.pop_front() : 33'h0;
        vecs++;
        if (b_rsp_valid !== 1'b1 || {b_rsp_err, b_rsp_old} !== exp) begin
            errs++; $display("FAIL err_rsp: valid=%b err=%b old=%h want valid=1 err=1 old=0", b_rsp_valid, b_rsp_err, b_rsp_old);
        end
        vecs++;
        if (b_lut_ce !== 3'b0 || b_lut_busy !== 3'b0 || b_lut_cdi !== 1'b0) begin
            errs++; $display("FAIL err_no_ce: ce=%b busy=%b cdi=%b want 0", b_lut_ce, b_lut_busy, b_lut_cdi);
        end
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;
        vecs++;
        if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
            errs++; $display("FAIL err_release: valid=%b ready=%b want 0 1", b_rsp_valid, b_req_ready);
        end
    endtask

    task automatic test_random();
        int acc, lat, bad;
        logic [1:0]  idx;
        logic [31:0] init;
        logic [32:0] exp;
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            idx  = 2'($urandom_range(0, 3));
            init = $urandom;
            do_load(idx, init, acc, lat, bad);
            exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
            vecs++;
            if ({rsp_err, rsp_old} !== exp || lat !== 33 || bad !== 0 || mem[idx] !== init) begin
                errs++;
                $display("FAIL rand_load%0d: idx=%0d old=%h lat=%0d bad=%0d model=%h want old=%h lat=33 bad=0 model=%h",
                         t, idx, rsp_old, lat, bad, mem[idx], exp[31:0], init);
            end
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int n = 0, spurious = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        req_valid = 1'b1; req_idx = 2'd3; req_init = 32'h13579BDF;
        tick();
        req_valid = 1'b0;
        repeat (15) tick();
        vecs++;
        if (lut_ce !== 4'b1000) begin errs++; $display("FAIL abort_pre_ce: got %b want 1000", lut_ce); end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (lut_ce !== 4'b0 || lut_busy !== 4'b0 || lut_cdi !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errs++; $display("FAIL abort_async: ce=%b busy=%b cdi=%b valid=%b ready=%b want 0",
                             lut_ce, lut_busy, lut_cdi, rsp_valid, req_ready);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        vecs++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0 || lut_ce !== 4'b0) spurious++;
            tick();
        end
        vecs++;
        if (spurious !== 0) begin errs++; $display("FAIL abort_no_rsp: %0d cycles with activity, want 0", spurious); end
    endtask

    initial begin
        mem[0] = 32'h00000000;
        mem[1] = 32'h12345678;
        mem[2] = 32'hCAFEF00D;
        mem[3] = 32'h0BADC0DE;
        test_reset();
        test_load();
        test_back_to_back();
        test_hold();
        test_err_idx();
        test_random();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cfglut_loader.md
CFGLUT_LOADER -- requirements
Module: cfglut_loader

Interface
REQ-001 SHALL have parameter NUM_LUT, default 4, giving the number of CFGLUT5 targets sharing this loader (range 1..16).
REQ-002 SHALL have parameter IDX_W, default 2, giving the target index width; it SHALL satisfy 2**IDX_W >= NUM_LUT.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  load request present.
REQ-006 req_ready  output  1  loader can accept a request.
REQ-007 req_idx  input  IDX_W  target LUT index.
REQ-008 req_init  input  32  new INIT contents for the target.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumer ready.
REQ-011 rsp_old  output  32  previous INIT contents read back from the target.
REQ-012 rsp_err  output  1  request rejected (index >= NUM_LUT).
REQ-013 lut_ce  output  NUM_LUT  per-target CE to the CFGLUT5 primitives.
REQ-014 lut_cdi  output  1  shared serial configuration data, MSB first.
REQ-015 lut_cdo  input  NUM_LUT  per-target CDO from the CFGLUT5 primitives.
REQ-016 lut_busy  output  NUM_LUT  target is mid-reconfiguration; its LUT output is invalid.

Function
REQ-017 State machine SHALL have states IDLE, SHIFT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on any edge where req_valid and req_ready are both 1.
REQ-019 Accept with req_idx < NUM_LUT: latch req_init and idx, clear the 5-bit bit counter, go to SHIFT.
REQ-020 Accept with req_idx >= NUM_LUT: go to RESP with rsp_err=1 and rsp_old=0; no lut_ce pulse.
REQ-021 In SHIFT, lut_ce[idx] SHALL be 1 for exactly 32 consecutive cycles; all other lut_ce bits SHALL stay 0.
REQ-022 During shift cycle k (k=0..31), lut_cdi SHALL equal latched init[31-k].
REQ-023 During shift cycle k, lut_cdo[idx] SHALL be sampled into rsp_old[31-k], which reconstructs the old contents MSB first.
REQ-024 After the edge ending shift cycle 31 (counter wrap 31->0), the state SHALL go to RESP with rsp_err=0.
REQ-025 Latency SHALL be 33 cycles from accept edge to the first rsp_valid=1 cycle for a valid request, and 1 cycle for an error request.
REQ-026 In RESP, rsp_valid=1 and rsp_old/rsp_err SHALL hold stable until rsp_ready=1; that edge returns the state to IDLE.
REQ-027 rsp_valid=0 in IDLE and SHIFT; in RESP, req_ready=0, so a new request cannot overlap an unconsumed response.
REQ-028 lut_busy[idx] SHALL be 1 during SHIFT only; it is the same as lut_ce.
REQ-029 lut_cdi SHALL be 0 whenever no lut_ce bit is 1.
REQ-030 Back-to-back requests SHALL sustain one load per 34 cycles when rsp_ready is tied to 1.

Reset
REQ-031 Asserting RST_N low SHALL immediately force state IDLE, lut_ce=0, lut_busy=0, lut_cdi=0, rsp_valid=0, rsp_err=0, rsp_old=0, counter=0 and latched data=0.
REQ-032 req_ready SHALL be 0 while RST_N is low and 1 from the first edge after release.
REQ-033 Reset during SHIFT SHALL abort the load with no response; the target's contents are then partial and the requester SHALL reload it.

Structure
REQ-034 Package cfglut_pkg SHALL hold the state enum, LUT_BITS=32 and the counter width 5.
REQ-035 One sub-module, cfglut_shifter, SHALL hold the 32-bit output shift register, the readback capture register and the bit counter; cfglut_loader holds the FSM and CE/busy decode.

Verification
REQ-036 Load idx=1 with init=0xDEADBEEF into a behavioural CFGLUT5 holding 0x12345678 -> lut_ce=0b0010 for 32 cycles, rsp_old=0x12345678 after 33 cycles, and the model then holds 0xDEADBEEF.
REQ-037 Two back-to-back loads to idx=0 (0xAAAA5555, then 0x0F0F0F0F) with rsp_ready=1 -> second rsp_old=0xAAAA5555; second accept occurs 34 cycles after the first.
REQ-038 NUM_LUT=3 with req_idx=3 -> rsp_valid after 1 cycle, rsp_err=1, rsp_old=0, lut_ce stays 0.
REQ-039 rsp_ready held 0 for 10 cycles after response -> rsp_valid and rsp_old stable, req_ready=0 throughout, IDLE on the 11th edge.
REQ-040 RST_N low at shift cycle 15 -> lut_ce=0 and lut_busy=0 asynchronously, no rsp_valid, req_ready=1 on the first edge after release.
